systolic_ctrl: RTL and testbench

- Sequencer for an N x N weight-stationary systolic array of DSP-based MAC PEs.
- Per job: streams N weight rows down the array, pulses weight capture, then feeds K activation vectors with per-row skew.
- Generates per-column result-valid strobes aligned to the bottom-row psum outputs, then signals done.
- Sits between the weight/activation buffers (valid/ready sources) and the array.

---
 rtl/systolic_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
//   Job sequencer for an N x N weight-stationary systolic array. For each job
//   it loads N weight rows into the array top, pulses a one-cycle weight
//   capture, streams k_len activation vectors into the left edge with a
//   per-row skew, and tracks when each column's bottom psum is valid.
//
// Ports
//   clk, rst            clock (rising edge) and async active-high reset
//   start, k_len        job request (seen in IDLE only) and vector count
//   busy, done          job in progress / one-cycle end-of-job pulse
//   wt_valid/wt_ready   weight-row handshake with the weight buffer
//   wt_data             incoming weight row, lane i = column i
//   weight_row          weight row driven into the array top
//   en_weight_pass      shift weights down one row this cycle
//   en_weight_capture   latch shifted weights into the PE weight registers
//   act_valid/act_ready activation-vector handshake with the act buffer
//   act_data            incoming activation vector, lane r = array row r
//   act_row_out         skewed activations into the array left edge
//   act_lane_en         per-row valid for act_row_out
//   out_valid           column c bottom psum_out holds a valid result
// -----------------------------------------------------------------------------
module systolic_ctrl #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PE_LAT     = 3,
  parameter int K_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [K_W-1:0]          k_len,
  output logic                    busy,
  output logic                    done,
  input  logic                    wt_valid,
  output logic                    wt_ready,
  input  logic [N*DATA_WIDTH-1:0] wt_data,
  output logic [N*DATA_WIDTH-1:0] weight_row,
  output logic                    en_weight_pass,
  output logic                    en_weight_capture,
  input  logic                    act_valid,
  output logic                    act_ready,
  input  logic [N*DATA_WIDTH-1:0] act_data,
  output logic [N*DATA_WIDTH-1:0] act_row_out,
  output logic [N-1:0]            act_lane_en,
  output logic [N-1:0]            out_valid
);

  // Column c result appears OV_BASE + c cycles after its vector is issued;
  // the last column sets both the valid delay-line depth and the drain time.
  localparam int OV_BASE   = N * PE_LAT;
  localparam int OV_DEPTH  = (N - 1) + OV_BASE;
  localparam int DRAIN_LEN = OV_DEPTH;
  localparam int DR_W      = $clog2(DRAIN_LEN + 1);
  localparam int WC_W      = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    CAPTURE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t          state_q;
  logic [WC_W-1:0] wcnt_q;
  logic [K_W-1:0]  remain_q;
  logic [DR_W-1:0] drain_q;
  logic [OV_DEPTH:1] ov_q;

  logic wt_beat;
  logic issue;

  // Handshakes and strobes are decoded from the state register only, so
  // they are glitch-free and all drop to 0 the moment reset asserts.
  assign wt_ready          = (state_q == LOAD_W);
  assign act_ready         = (state_q == STREAM);
  assign en_weight_capture = (state_q == CAPTURE);
  assign done              = (state_q == DONE);
  assign busy              = (state_q != IDLE);

  assign wt_beat = wt_valid & wt_ready;
  assign issue   = act_valid & act_ready;

  // Weight rows pass straight through on an accepted beat so the array
  // shifts the row in the same cycle it is handed over.
  assign en_weight_pass = wt_beat;
  assign weight_row     = wt_beat ? wt_data : '0;

  // Job FSM. remain_q holds the vectors still to issue; because k_len == 0
  // skips STREAM, it is never zero inside STREAM, so act_ready needs no
  // separate count compare and a full-scale k_len cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      remain_q <= '0;
      drain_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            remain_q <= k_len;
            wcnt_q   <= '0;
            state_q  <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (wt_beat) begin
            if (wcnt_q == WC_W'(N - 1)) begin
              state_q <= CAPTURE;
            end else begin
              wcnt_q <= wcnt_q + WC_W'(1);
            end
          end
        end
        CAPTURE: begin
          state_q <= (remain_q == '0) ? DONE : STREAM;
        end
        STREAM: begin
          if (issue) begin
            remain_q <= remain_q - K_W'(1);
            if (remain_q == K_W'(1)) begin
              drain_q <= DR_W'(DRAIN_LEN - 1);
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q <= DONE;
          end else begin
            drain_q <= drain_q - DR_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Per-row skew: row r sees its element r cycles after issue. Non-issue
  // cycles enter as zero-data bubbles so gaps travel with the wavefront.
  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_in;
    assign lane_in = issue ? act_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;

    if (r == 0) begin : g_direct
      assign act_row_out[DATA_WIDTH-1:0] = lane_in;
      assign act_lane_en[0]              = issue;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] data_q [0:r-1];
      logic [r-1:0]          en_q;

      // Shift register of depth r carrying data and its valid together.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          en_q <= '0;
          for (int d = 0; d < r; d++) begin
            data_q[d] <= '0;
          end
        end else begin
          en_q[0]   <= issue;
          data_q[0] <= lane_in;
          for (int d = 1; d < r; d++) begin
            en_q[d]   <= en_q[d-1];
            data_q[d] <= data_q[d-1];
          end
        end
      end

      assign act_row_out[r*DATA_WIDTH +: DATA_WIDTH] = data_q[r-1];
      assign act_lane_en[r]                          = en_q[r-1];
    end
  end

  // One shared delay line of issue flags; ov_q[d] is the issue flag from
  // d cycles ago, and each column taps its own depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q <= '0;
    end else begin
      ov_q <= {ov_q[OV_DEPTH-1:1], issue};
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_ov
    assign out_valid[c] = ov_q[c + OV_BASE];
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
//   Directed bench for systolic_ctrl (N=4, PE_LAT=3). Each job is driven one
//   cycle at a time; per-cycle output bits are collected into 64-bit maps
//   indexed by the cycle offset from start and compared with hand-derived
//   expected maps. Weight and activation payloads carry a per-beat pattern
//   so ordering and bubble zeroing are checked too.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int PE_LAT = 3;
  localparam int K_W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [K_W-1:0]    k_len;
  logic              busy;
  logic              done;
  logic              wt_valid;
  logic              wt_ready;
  logic [N*DW-1:0]   wt_data;
  logic [N*DW-1:0]   weight_row;
  logic              en_weight_pass;
  logic              en_weight_capture;
  logic              act_valid;
  logic              act_ready;
  logic [N*DW-1:0]   act_data;
  logic [N*DW-1:0]   act_row_out;
  logic [N-1:0]      act_lane_en;
  logic [N-1:0]      out_valid;

  systolic_ctrl #(
    .N(N), .DATA_WIDTH(DW), .PE_LAT(PE_LAT), .K_W(K_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .done(done),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
    .weight_row(weight_row), .en_weight_pass(en_weight_pass),
    .en_weight_capture(en_weight_capture),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .act_row_out(act_row_out), .act_lane_en(act_lane_en),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  int rc;
  int wtAcc;
  int actAcc;
  int wtErr;
  int actErr;
  int laneCnt [N];
  logic [63:0] passMap, capMap, doneMap, busyMap, rdyMap;
  logic [63:0] laneMap [N];
  logic [63:0] ovMap [N];

  // Weight row number v: lane i = A0 + 4v + i.
  function automatic logic [N*DW-1:0] mkWt(input int v);
    logic [N*DW-1:0] res;
    res = '0;
    for (int i = 0; i < N; i++) res[i*DW +: DW] = DW'(160 + v*4 + i);
    return res;
  endfunction

  // Activation vector number v: lane r = 16(v+1) + r + 1.
  function automatic logic [N*DW-1:0] mkAct(input int v);
    logic [N*DW-1:0] res;
    res = '0;
    for (int r = 0; r < N; r++) res[r*DW +: DW] = DW'((v + 1)*16 + r + 1);
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearMon;
    rc = 0; wtAcc = 0; actAcc = 0; wtErr = 0; actErr = 0;
    passMap = '0; capMap = '0; doneMap = '0; busyMap = '0; rdyMap = '0;
    for (int r = 0; r < N; r++) begin
      laneCnt[r] = 0; laneMap[r] = '0; ovMap[r] = '0;
    end
    wt_data  = mkWt(0);
    act_data = mkAct(0);
  endtask

  // Record one cycle of outputs (called mid-cycle, away from the edge).
  task automatic sample;
    logic [N*DW-1:0] e;
    if (rc < 64) begin
      passMap[rc] = en_weight_pass;
      capMap[rc]  = en_weight_capture;
      doneMap[rc] = done;
      busyMap[rc] = busy;
      rdyMap[rc]  = act_ready;
      for (int r = 0; r < N; r++) begin
        laneMap[r][rc] = act_lane_en[r];
        ovMap[r][rc]   = out_valid[r];
      end
    end
    if (en_weight_pass) begin
      if (weight_row !== mkWt(wtAcc)) wtErr++;
    end else if (weight_row !== '0) begin
      wtErr++;
    end
    for (int r = 0; r < N; r++) begin
      e = mkAct(laneCnt[r]);
      if (act_lane_en[r]) begin
        if (act_row_out[r*DW +: DW] !== e[r*DW +: DW]) actErr++;
        laneCnt[r]++;
      end else if (act_row_out[r*DW +: DW] !== '0) begin
        actErr++;
      end
    end
    if (wt_valid && wt_ready) wtAcc++;
    if (act_valid && act_ready) actAcc++;
    rc++;
  endtask

  task automatic step;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    wt_data  = mkWt(wtAcc);
    act_data = mkAct(actAcc);
  endtask

  // Inputs for cycle offset i of test id (called just after the edge).
  task automatic applyStimulus(input int id, input int i);
    start     = (i == 0);
    wt_valid  = 1'b1;
    act_valid = 1'b1;
    case (id)
      2: begin
        wt_valid  = i[0];
        act_valid = !(i == 11 || i == 12);
      end
      4: begin
        start = (i == 0 || i == 7 || i == 10);
        if (i != 0) k_len = K_W'(9);
      end
      5: begin
        if (i == 7) begin
          rst = 1'b1;
          #1;
          checkOutput("t5 rst ctrl", 64'({busy, done, wt_ready, en_weight_pass,
                      en_weight_capture, act_ready, act_lane_en, out_valid}), 64'd0);
          checkOutput("t5 rst actrow", 64'(act_row_out), 64'd0);
          checkOutput("t5 rst wtrow", 64'(weight_row), 64'd0);
        end
        if (i == 9) rst = 1'b0;
      end
      6: start = (i == 0 || i == 23);
      default: ;
    endcase
  endtask

  task automatic runTest(input int id, input logic [K_W-1:0] kl, input int n);
    clearMon();
    k_len = kl;
    applyStimulus(id, 0);
    for (int i = 1; i <= n; i++) begin
      step();
      applyStimulus(id, i);
    end
    step();
    start = 1'b0; wt_valid = 1'b0; act_valid = 1'b0;
  endtask

  task automatic checkJob(input string t, input logic [63:0] passE,
                          input logic [63:0] capE, input logic [63:0] doneE,
                          input logic [63:0] busyE, input logic [63:0] rdyE,
                          input logic [63:0] issE);
    checkOutput({t, " pass"}, passMap, passE);
    checkOutput({t, " capture"}, capMap, capE);
    checkOutput({t, " done"}, doneMap, doneE);
    checkOutput({t, " busy"}, busyMap, busyE);
    checkOutput({t, " act_ready"}, rdyMap, rdyE);
    for (int r = 0; r < N; r++) begin
      checkOutput($sformatf("%s lane%0d", t, r), laneMap[r], issE << r);
      checkOutput($sformatf("%s ov%0d", t, r), ovMap[r], issE << (r + N*PE_LAT));
    end
    checkOutput({t, " wt data"}, 64'(wtErr), 64'd0);
    checkOutput({t, " act data"}, 64'(actErr), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0;
    wt_valid = 1'b0; act_valid = 1'b0; wt_data = '0; act_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ctrl", 64'({busy, done, wt_ready, en_weight_pass,
                en_weight_capture, act_ready, act_lane_en, out_valid}), 64'd0);
    checkOutput("reset rows", 64'(weight_row | act_row_out), 64'd0);
    rst = 1'b0;

    // Basic job, valids held high (also: held wt_valid not eaten by CAPTURE).
    runTest(1, 16'd4, 40);
    checkJob("t1", 64'h1E, 64'd1 << 5, 64'd1 << 25, 64'h1FFFFFF << 1,
             64'hF << 6, 64'hF << 6);

    // Weight beats every other cycle, 2-cycle act gap after vector 2.
    runTest(2, 16'd4, 40);
    checkJob("t2", 64'hAA, 64'd1 << 8, 64'd1 << 30, 64'h3FFFFFFF << 1,
             64'h3F << 9, 64'h6600);

    // Empty job.
    runTest(3, 16'd0, 20);
    checkJob("t3", 64'h1E, 64'd1 << 5, 64'd1 << 6, 64'h7E, 64'd0, 64'd0);

    // start pulsed in STREAM and DRAIN is ignored.
    runTest(4, 16'd3, 35);
    checkJob("t4", 64'h1E, 64'd1 << 5, 64'd1 << 24, 64'hFFFFFF << 1,
             64'h7 << 6, 64'h7 << 6);

    // Reset during STREAM, then a fresh normal job.
    runTest(5, 16'd4, 20);
    checkOutput("t5 pass", passMap, 64'h1E);
    checkOutput("t5 done", doneMap, 64'd0);
    checkOutput("t5 busy", busyMap, 64'h7E);
    checkOutput("t5 act_ready", rdyMap, 64'd1 << 6);
    checkOutput("t5 lane0", laneMap[0], 64'd1 << 6);
    for (int r = 1; r < N; r++)
      checkOutput($sformatf("t5 lane%0d", r), laneMap[r], 64'd0);
    for (int r = 0; r < N; r++)
      checkOutput($sformatf("t5 ov%0d", r), ovMap[r], 64'd0);
    runTest(1, 16'd4, 40);
    checkJob("t5b", 64'h1E, 64'd1 << 5, 64'd1 << 25, 64'h1FFFFFF << 1,
             64'hF << 6, 64'hF << 6);

    // Back-to-back k_len=1 jobs, second start right after done.
    runTest(6, 16'd1, 55);
    checkJob("t6", 64'h1E | (64'hF << 24), (64'd1 << 5) | (64'd1 << 28),
             (64'd1 << 22) | (64'd1 << 45),
             (64'h3FFFFF << 1) | (64'h3FFFFF << 24),
             (64'd1 << 6) | (64'd1 << 29), (64'd1 << 6) | (64'd1 << 29));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
